br_lite_local_injector: RTL
===========================

# br_lite_local_injector

Local-port injection scheduler for a BrLite router. It shares the router's single local input between `NREQ` local requesters using round-robin arbitration, and builds each outgoing `br_data_t` flit with this node's address and a per-node message id. It serialises injections so that only one locally-originated broadcast is outstanding at a time: the next injection waits until the router deasserts `local_busy_o`. It sits between the PE-side requesters and router local port `BR_LOCAL` (`flit_i`/`req_i`/`ack_o`).

## Interface
- `NREQ`, default 4: number of local requesters (≥2).
- `ADDRESS`, default 0: 16-bit node address, written into `flit_o.source`.

- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `src_req_i`  in  NREQ  per-requester request, four-phase.
- `src_ack_o`  out  NREQ  per-requester acknowledge; at most one bit high.
- `src_target_i`  in  NREQ×16  requested target address.
- `src_service_i`  in  NREQ×(width of `br_data_t.service`)  requested service.
- `src_payload_i`  in  NREQ×(width of `br_data_t.payload`)  payload.
- `router_busy_i`  in  1  router `local_busy_o`.
- `flit_o`  out  `br_data_t`  flit to router local input.
- `req_o`  out  1  request to router local input.
- `ack_i`  in  1  router local `ack_o`.
- `grant_o`  out  NREQ  one-hot currently served requester; all zero in IDLE.
- `err_o`  out  1  one-cycle pulse when a request is rejected.

## Operation
- **State machine:** IDLE, ARB, LOAD, SEND, RELEASE.
- **IDLE → ARB:** when `src_req_i != 0`, `!router_busy_i` and `!ack_i`. Otherwise stay in IDLE.
- **ARB → LOAD:**
  - Round-robin pick: the first requesting index strictly after `last_grant`, wrapping modulo `NREQ`.
  - Latch it into `grant`; `last_grant` takes the same value.
  - If only `last_grant` itself requests, it is granted again.
- **LOAD:**
  - If `src_service_i[grant]` is `BR_SVC_ALL` or `BR_SVC_TGT`, register the flit and go to SEND:
    - `source` = `ADDRESS`
    - `target`, `service`, `payload` from the granted requester
    - `id` = `id_cnt`
  - Any other service, including `BR_SVC_CLEAR`, is rejected: go to RELEASE with `err_o` pulsed in RELEASE's first cycle. The flit is not updated and `id_cnt` is unchanged.
- **SEND:**
  - `req_o` = 1.
  - On `ack_i` = 1: `id_cnt` ← `id_cnt` + 1, wrapping modulo 2^(width of `id`); go to RELEASE. `req_o` drops in the same transition.
- **RELEASE:**
  - `src_ack_o[grant]` = 1 while `src_req_i[grant]` = 1.
  - When `src_req_i[grant]` = 0, go to IDLE.
- **Requester obligation:** target, service and payload stay stable from raising `src_req_i` until `src_ack_o` rises.
- **Flit stability:** `flit_o` holds its registered value outside LOAD, so it is stable for the whole SEND.
- **Busy gating:** the router raises busy during its write state, which precedes its ack. IDLE therefore blocks until the router's clear period ends. If the router ignored the flit as a duplicate, busy stays low and the next arbitration proceeds immediately.
- **Requests during service:** new `src_req_i` bits arriving during SEND or RELEASE are held off and considered at the next ARB.
- **Withdrawn request:** if the granted requester drops its request before `src_ack_o`, behaviour is unchanged. The flit is still sent, and RELEASE exits in its first cycle.

## Timing
- **Reset values:**
  - `req_o`, `src_ack_o`, `grant_o`, `err_o` = 0; `flit_o` = 0; `id_cnt` = 0.
  - `last_grant` = `NREQ` − 1, so the first grant goes to index 0.
  - State = IDLE.
- **Reset mid-operation:** forces IDLE immediately and drops `req_o`. The router then returns its ack for a dropped request and exits its ack state on `req_o` low; IDLE waits for `ack_i` = 0.
- **Latency:** `src_req_i` sampled high in IDLE at cycle 0 gives ARB at 1, LOAD at 2, and `req_o` high at cycle 3.
- **Router handshake:** `ack_i` sampled high at cycle n gives `req_o` low and `src_ack_o` high at n+1.
- **Minimum spacing:** back-to-back injections (busy never asserted) are at least 5 cycles apart, plus the requester's release time.
- **Outputs:** `grant_o` is valid from ARB+1 through RELEASE. All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Configuration
- **`BRLITE_INJ_STATS_EN` defined:**
  - Adds output `inj_count_o` (32-bit), incremented on every SEND→RELEASE transition and saturating at 2^32−1.
  - Adds output `rej_count_o` (16-bit), incremented on every rejection and saturating.
  - Both reset to 0.
- **Undefined:** both ports and their counters are absent; all other behaviour is identical.

## Test plan
- **Single send:** reset, `ADDRESS`=16'h0102; requester 0 issues target 16'h0304, `BR_SVC_TGT`, payload 5, router acks after 2 cycles. Required: `req_o` at cycle 3, `flit_o` = {source 0102, target 0304, id 0}, `src_ack_o[0]` one cycle after ack, `id_cnt`=1.
- **Round-robin:** requesters 0, 1, 3 request together continuously, busy low. Required grant order 0, 1, 3, 0, with ids 0, 1, 2, 3.
- **Busy gating:** after an injection, hold `router_busy_i`=1 for 100 cycles while requester 2 requests. Required: no ARB during busy; `req_o` rises 3 cycles after busy falls.
- **Reject:** requester 1 requests `BR_SVC_CLEAR`. Required: `req_o` never rises, `err_o` pulses once, `src_ack_o[1]` asserted, `id_cnt` unchanged (and `rej_count_o`=1 with `BRLITE_INJ_STATS_EN`).
- **Id wrap:** 2^w + 1 back-to-back sends, where w is the width of `id`. Required: the last flit carries id 0.
- **Reset during SEND:** assert `rst_ni`=0 while `req_o`=1. Required: all outputs 0 immediately; after release, no ARB until `ack_i`=0.

Source files
------------

// File: rtl/br_lite_local_injector.sv
// br_lite_local_injector: round-robin local-port injection scheduler for a BrLite router.
// It shares the router's local input between NREQ requesters and stamps each flit
// with this node's address and a wrapping per-node message id. Only one locally
// originated broadcast is in flight at a time; IDLE waits for the router to drop busy.
// Optional build macro: BRLITE_INJ_STATS_EN adds saturating injection/rejection counters.

package br_lite_pkg;
   localparam int BR_SVC_W     = 2;
   localparam int BR_ID_W      = 4;
   localparam int BR_PAYLOAD_W = 32;

   typedef enum logic [BR_SVC_W-1:0] {
      BR_SVC_ALL   = 2'd0,
      BR_SVC_TGT   = 2'd1,
      BR_SVC_CLEAR = 2'd2,
      BR_SVC_MON   = 2'd3
   } br_svc_t;

   typedef struct packed {
      logic [BR_PAYLOAD_W-1:0] payload;
      logic [15:0]             source;
      logic [15:0]             target;
      logic [BR_ID_W-1:0]      id;
      br_svc_t                 service;
   } br_data_t;
endpackage

module br_lite_local_injector
   import br_lite_pkg::*;
#(
   parameter int          NREQ    = 4,
   parameter logic [15:0] ADDRESS = 16'h0000
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic [NREQ-1:0]                      src_req_i,
   output logic [NREQ-1:0]                      src_ack_o,
   input  logic [NREQ-1:0][15:0]                src_target_i,
   input  logic [NREQ-1:0][BR_SVC_W-1:0]        src_service_i,
   input  logic [NREQ-1:0][BR_PAYLOAD_W-1:0]    src_payload_i,
   input  logic                                 router_busy_i,
   output br_data_t                             flit_o,
   output logic                                 req_o,
   input  logic                                 ack_i,
   output logic [NREQ-1:0]                      grant_o,
   output logic                                 err_o
`ifdef BRLITE_INJ_STATS_EN
   ,
   output logic [31:0]                          inj_count_o,
   output logic [15:0]                          rej_count_o
`endif
);

   localparam int IDX_W = $clog2(NREQ);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARB     = 3'd1,
      S_LOAD    = 3'd2,
      S_SEND    = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   state_t               state_reg;
   logic [IDX_W-1:0]     grant_idx_reg;
   logic [IDX_W-1:0]     last_grant_reg;
   logic [NREQ-1:0]      grant_reg;
   logic [NREQ-1:0]      src_ack_reg;
   logic                 req_reg;
   logic                 err_reg;
   br_data_t             flit_reg;
   logic [BR_ID_W-1:0]   id_cnt_reg;
`ifdef BRLITE_INJ_STATS_EN
   logic [31:0]          inj_count_reg;
   logic [15:0]          rej_count_reg;
`endif

   logic                 pick_valid;
   logic [IDX_W-1:0]     pick_idx;
   logic [IDX_W-1:0]     cand;
   br_svc_t              svc;
   logic                 svc_ok;

   // Round-robin pick: first requester strictly after last_grant, wrapping; last_grant itself last.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = IDX_W'((int'(last_grant_reg) + k) % NREQ);
         if (src_req_i[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Only broadcast-to-all and targeted services may be injected from the local port.
   always_comb begin
      svc    = br_svc_t'(src_service_i[grant_idx_reg]);
      svc_ok = (svc == BR_SVC_ALL) || (svc == BR_SVC_TGT);
   end

   // Injection FSM with all outputs held in registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg      <= S_IDLE;
         grant_idx_reg  <= '0;
         last_grant_reg <= IDX_W'(NREQ - 1);
         grant_reg      <= '0;
         src_ack_reg    <= '0;
         req_reg        <= 1'b0;
         err_reg        <= 1'b0;
         flit_reg       <= '0;
         id_cnt_reg     <= '0;
`ifdef BRLITE_INJ_STATS_EN
         inj_count_reg  <= '0;
         rej_count_reg  <= '0;
`endif
      end else begin
         err_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               // ack_i must be low so a stale ack after a reset is not mistaken for a new one
               if ((|src_req_i) && !router_busy_i && !ack_i) begin
                  state_reg <= S_ARB;
               end
            end
            S_ARB: begin
               if (pick_valid) begin
                  grant_idx_reg  <= pick_idx;
                  last_grant_reg <= pick_idx;
                  grant_reg      <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                  state_reg      <= S_LOAD;
               end else begin
                  // every request vanished between IDLE and ARB
                  state_reg <= S_IDLE;
               end
            end
            S_LOAD: begin
               if (svc_ok) begin
                  flit_reg.source  <= ADDRESS;
                  flit_reg.target  <= src_target_i[grant_idx_reg];
                  flit_reg.service <= svc;
                  flit_reg.payload <= src_payload_i[grant_idx_reg];
                  flit_reg.id      <= id_cnt_reg;
                  req_reg          <= 1'b1;
                  state_reg        <= S_SEND;
               end else begin
                  err_reg     <= 1'b1;
                  src_ack_reg <= grant_reg & src_req_i;
                  state_reg   <= S_RELEASE;
`ifdef BRLITE_INJ_STATS_EN
                  if (rej_count_reg != '1) begin
                     rej_count_reg <= rej_count_reg + 16'd1;
                  end
`endif
               end
            end
            S_SEND: begin
               if (ack_i) begin
                  req_reg     <= 1'b0;
                  id_cnt_reg  <= id_cnt_reg + 1'b1;
                  src_ack_reg <= grant_reg & src_req_i;
                  state_reg   <= S_RELEASE;
`ifdef BRLITE_INJ_STATS_EN
                  if (inj_count_reg != '1) begin
                     inj_count_reg <= inj_count_reg + 32'd1;
                  end
`endif
               end
            end
            S_RELEASE: begin
               // four-phase: hold the ack until the requester lowers its request
               if (!src_req_i[grant_idx_reg]) begin
                  src_ack_reg <= '0;
                  grant_reg   <= '0;
                  state_reg   <= S_IDLE;
               end
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign src_ack_o = src_ack_reg;
   assign grant_o   = grant_reg;
   assign req_o     = req_reg;
   assign err_o     = err_reg;
   assign flit_o    = flit_reg;
`ifdef BRLITE_INJ_STATS_EN
   assign inj_count_o = inj_count_reg;
   assign rej_count_o = rej_count_reg;
`endif

endmodule
